// File: rtl/lb_cmd_master_pkg.sv
// Shared types and constants for the lb_cmd_master local-bus initiator.
package lb_cmd_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_CHK,
    ST_ADDR,
    ST_WDATA,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_TX
  } state_t;

  localparam logic [3:0] CMD_WR = 4'h1;
  localparam logic [3:0] CMD_RD = 4'h2;

  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 4;
  localparam int WORD_BYTES = 4;

  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);
  localparam logic [1:0] TX_LAST   = 2'(WORD_BYTES - 1);

  // Byte lane idx 0 is the most significant byte (frames are MSB first).
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lb_tx_serializer.sv
// Loads a 32-bit word and emits it as 4 bytes, MSB first, over a valid/ready byte link.
module lb_tx_serializer
  import lb_cmd_master_pkg::*;
(
  input  logic        clk_lb,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        tx_ready,
  output logic [7:0]  tx_d,
  output logic        tx_valid,
  output logic        last_hs
);

  logic [31:0] shreg;
  logic [1:0]  cnt;

  always_ff @(posedge clk_lb) begin
    if (!reset) begin
      shreg    <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= word;
      cnt      <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      shreg <= {shreg[23:0], 8'h00};
      cnt   <= cnt + 2'd1;
      if (cnt == TX_LAST) tx_valid <= 1'b0;
    end
  end

  assign tx_d    = shreg[31:24];
  assign last_hs = tx_valid && tx_ready && (cnt == TX_LAST);

endmodule

// File: rtl/lb_cmd_master.sv
// lb_cmd_master: turns host command bytes into lb_wr/lb_rd strobes and returns read data as bytes.
// Define LB_CMD_MASTER_BURST_EN to accept multi-word commands (cmd[7:4] = word count - 1).
module lb_cmd_master
  import lb_cmd_master_pkg::*;
#(
  parameter logic [15:0] timeout_len  = 16'd255,
  parameter logic [31:0] timeout_data = 32'hDEADBEEF
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic [7:0]  rx_d,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_d,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic        busy,
  output logic        err_pulse
);

  state_t      state, state_next;
  logic [7:0]  cmd;
  logic [1:0]  byte_cnt;
  logic [15:0] to_cnt;
  logic [3:0]  words_left;
  logic [3:0]  burst_len;
  logic        rx_hs, cmd_ok, cmd_is_rd, more_words;
  logic        rd_take, rd_expire, tx_load, tx_last_hs;

  assign rx_hs      = rx_valid && rx_ready;
  assign cmd_is_rd  = (cmd[3:0] == CMD_RD);
  assign more_words = (words_left != 4'h0);

`ifdef LB_CMD_MASTER_BURST_EN
  assign cmd_ok    = (cmd[3:0] == CMD_WR) || (cmd[3:0] == CMD_RD);
  assign burst_len = cmd[7:4];
`else
  assign cmd_ok    = (cmd[7:4] == 4'h0) && ((cmd[3:0] == CMD_WR) || (cmd[3:0] == CMD_RD));
  assign burst_len = 4'h0;
`endif

  // Real data seen on the expiry cycle wins over the timeout.
  assign rd_take   = (state == ST_RD_WAIT) && lb_rd_rdy;
  assign rd_expire = (state == ST_RD_WAIT) && !lb_rd_rdy && (to_cnt == timeout_len);
  assign tx_load   = rd_take || rd_expire;
  assign err_pulse = ((state == ST_CMD_CHK) && !cmd_ok) || rd_expire;

  lb_tx_serializer u_tx (
    .clk_lb   (clk_lb),
    .reset    (reset),
    .load     (tx_load),
    .word     (lb_rd_rdy ? lb_rd_d : timeout_data),
    .tx_ready (tx_ready),
    .tx_d     (tx_d),
    .tx_valid (tx_valid),
    .last_hs  (tx_last_hs)
  );

  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (avoids a latch).
    state_next = state;
    case (state)
      ST_IDLE:    if (rx_hs) state_next = ST_CMD_CHK;
      ST_CMD_CHK: state_next = cmd_ok ? ST_ADDR : ST_IDLE;
      ST_ADDR:    if (rx_hs && byte_cnt == ADDR_LAST) state_next = cmd_is_rd ? ST_RD : ST_WDATA;
      ST_WDATA:   if (rx_hs && byte_cnt == DATA_LAST) state_next = ST_WR;
      ST_WR:      state_next = more_words ? ST_WDATA : ST_IDLE;
      ST_RD:      state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (tx_load) state_next = ST_TX;
      ST_TX:      if (tx_last_hs) state_next = more_words ? ST_RD : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Strobes and handshakes are registered from state_next so they track the state
  // exactly, yet all read 0 in the cycle after a reset edge.
  always_ff @(posedge clk_lb) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      lb_wr      <= 1'b0;
      lb_rd      <= 1'b0;
      lb_addr    <= '0;
      lb_wr_d    <= '0;
      cmd        <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      words_left <= '0;
    end else begin
      // NOTE: non-blocking updates so every read in this block sees the pre-edge value.
      state    <= state_next;
      rx_ready <= (state_next inside {ST_IDLE, ST_ADDR, ST_WDATA});
      busy     <= (state_next != ST_IDLE);
      lb_wr    <= (state_next == ST_WR);
      lb_rd    <= (state_next == ST_RD);

      if (state == ST_IDLE && rx_hs) cmd <= rx_d;

      if (state == ST_CMD_CHK) begin
        byte_cnt   <= '0;
        words_left <= burst_len;
      end

      if (state == ST_ADDR && rx_hs) begin
        lb_addr  <= put_byte(lb_addr, byte_cnt, rx_d);
        byte_cnt <= byte_cnt + 2'd1;
      end

      if (state == ST_WDATA && rx_hs) begin
        lb_wr_d  <= put_byte(lb_wr_d, byte_cnt, rx_d);
        byte_cnt <= byte_cnt + 2'd1;
      end

      // Next burst word: the address steps only once the current word is finished.
      if ((state == ST_WR && more_words) || (state == ST_TX && tx_last_hs && more_words)) begin
        lb_addr    <= lb_addr + 32'd4;
        words_left <= words_left - 4'd1;
      end

      if (state == ST_RD)           to_cnt <= '0;
      else if (state == ST_RD_WAIT) to_cnt <= to_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_lb_cmd_master.sv
// Directed self-checking bench for lb_cmd_master (timeout_len overridden to 8).
module tb_lb_cmd_master;

  logic        clk_lb = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_d = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_d;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        lb_wr, lb_rd;
  logic [31:0] lb_addr, lb_wr_d;
  logic [31:0] lb_rd_d = 32'h0;
  logic        lb_rd_rdy = 1'b0;
  logic        busy, err_pulse;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int err_base;
  logic [7:0]  tx_q[$];
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_d = 8'h00;
  logic [13:0] ctl;
  logic [31:0] word;

  assign ctl = {rx_ready, tx_valid, lb_wr, lb_rd, busy, err_pulse, tx_d};

  lb_cmd_master #(.timeout_len(16'd8), .timeout_data(32'hDEADBEEF)) dut (
    .clk_lb    (clk_lb),
    .reset     (reset),
    .rx_d      (rx_d),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_d      (tx_d),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .lb_wr     (lb_wr),
    .lb_rd     (lb_rd),
    .lb_addr   (lb_addr),
    .lb_wr_d   (lb_wr_d),
    .lb_rd_d   (lb_rd_d),
    .lb_rd_rdy (lb_rd_rdy),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  always #5 clk_lb = ~clk_lb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Event log sampled mid-cycle; a stalled byte must reappear unchanged.
  always @(negedge clk_lb) begin
    if (lb_wr) wr_cnt++;
    if (lb_rd) rd_cnt++;
    if (err_pulse) err_cnt++;
    if (hold_pend) begin
      check("tx_hold_valid", 32'(tx_valid), 32'd1);
      check("tx_hold_d", 32'(tx_d), 32'(hold_d));
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_d);
    hold_pend = tx_valid && !tx_ready;
    hold_d    = tx_d;
  end

  task automatic tick();
    @(posedge clk_lb);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    tick();
    rx_d = b;
    rx_valid = 1'b1;
    @(negedge clk_lb);
    while (!rx_ready && n < 40) begin
      @(negedge clk_lb);
      n++;
    end
    check("rx_accept", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [31:0] a);
    send_byte(c);
    send_byte(a[31:24]);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic wait_rd(input string tag);
    int n = 0;
    @(negedge clk_lb);
    while (!lb_rd && n < 20) begin
      @(negedge clk_lb);
      n++;
    end
    check(tag, 32'(lb_rd), 32'd1);
  endtask

  task automatic collect_tx(input bit bp, input bit expect_idle, output logic [31:0] w);
    int n = 0;
    tx_q.delete();
    tx_ready = bp ? 1'b0 : 1'b1;
    while (tx_q.size() < 4 && n < 200) begin
      tick();
      n++;
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("tx_count", 32'(tx_q.size()), 32'd4);
    w = (tx_q.size() >= 4) ? {tx_q[0], tx_q[1], tx_q[2], tx_q[3]} : 32'hxxxxxxxx;
    tx_ready = 1'b0;
    if (expect_idle) begin
      @(negedge clk_lb);
      check("idle_after_tx", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk_lb);
    check("rst_ctl", 32'(ctl), 32'd0);
    check("rst_addr", lb_addr, 32'd0);
    check("rst_wr_d", lb_wr_d, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk_lb);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single write
    tx_q.delete();
    send_hdr(8'h01, 32'h0000_0004);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    @(negedge clk_lb);
    check("wr_strobe", 32'(lb_wr), 32'd1);
    check("wr_addr", lb_addr, 32'h0000_0004);
    check("wr_data", lb_wr_d, 32'h1234_5678);
    tick();
    @(negedge clk_lb);
    check("wr_one_cycle", 32'(lb_wr), 32'd0);
    check("wr_idle", 32'(busy), 32'd0);
    check("wr_count", 32'(wr_cnt), 32'd1);
    check("wr_no_tx", 32'(tx_q.size()), 32'd0);

    // Read; rdy in the strobe cycle is ignored, real rdy 3 cycles later
    err_base = err_cnt;
    tick();
    send_hdr(8'h02, 32'h0000_0000);
    wait_rd("rd_strobe");
    check("rd_addr", lb_addr, 32'h0000_0000);
    lb_rd_rdy = 1'b1; lb_rd_d = 32'h1111_1111;
    tick();
    lb_rd_rdy = 1'b0;
    tick();
    tick();
    lb_rd_rdy = 1'b1; lb_rd_d = 32'hCAFE_F00D;
    tick();
    lb_rd_rdy = 1'b0;
    collect_tx(1'b0, 1'b1, word);
    check("rd_word", word, 32'hCAFE_F00D);
    check("rd_no_err", 32'(err_cnt - err_base), 32'd0);
    check("rd_count", 32'(rd_cnt), 32'd1);

    // Timeout: error on counter==8, timeout word returned
    err_base = err_cnt;
    tick();
    send_hdr(8'h02, 32'h0000_0010);
    wait_rd("to_strobe");
    repeat (8) tick();
    @(negedge clk_lb);
    check("to_no_err_early", 32'(err_pulse), 32'd0);
    tick();
    @(negedge clk_lb);
    check("to_err_pulse", 32'(err_pulse), 32'd1);
    tick();
    collect_tx(1'b0, 1'b1, word);
    check("to_word", word, 32'hDEAD_BEEF);
    check("to_err_once", 32'(err_cnt - err_base), 32'd1);

    // Ready on the expiry cycle: real data, no error
    err_base = err_cnt;
    tick();
    send_hdr(8'h02, 32'h0000_0020);
    wait_rd("tie_strobe");
    repeat (9) tick();
    lb_rd_rdy = 1'b1; lb_rd_d = 32'h5A5A_C3C3;
    @(negedge clk_lb);
    check("tie_no_err", 32'(err_pulse), 32'd0);
    tick();
    lb_rd_rdy = 1'b0;
    collect_tx(1'b0, 1'b1, word);
    check("tie_word", word, 32'h5A5A_C3C3);
    check("tie_err_cnt", 32'(err_cnt - err_base), 32'd0);

    // Backpressure on the byte stream
    tick();
    send_hdr(8'h02, 32'h0000_0030);
    wait_rd("bp_strobe");
    tick();
    lb_rd_rdy = 1'b1; lb_rd_d = 32'h8421_F00F;
    tick();
    lb_rd_rdy = 1'b0;
    collect_tx(1'b1, 1'b1, word);
    check("bp_word", word, 32'h8421_F00F);
    tx_ready = 1'b1;
    repeat (4) tick();
    check("bp_no_extra", 32'(tx_q.size()), 32'd4);
    tx_ready = 1'b0;

    // Unknown command: consumed, error, bus regs untouched
    err_base = err_cnt;
    send_byte(8'h07);
    @(negedge clk_lb);
    check("bad_cmd_err", 32'(err_pulse), 32'd1);
    tick();
    @(negedge clk_lb);
    check("bad_cmd_rx_ready", 32'(rx_ready), 32'd1);
    check("bad_cmd_busy", 32'(busy), 32'd0);
    check("bad_cmd_addr", lb_addr, 32'h0000_0030);
    check("bad_cmd_wr_d", lb_wr_d, 32'h1234_5678);
    check("bad_cmd_err_cnt", 32'(err_cnt - err_base), 32'd1);

`ifdef LB_CMD_MASTER_BURST_EN
    // Two-word burst read wrapping the address
    send_hdr(8'h12, 32'hFFFF_FFFC);
    wait_rd("burst_rd0");
    check("burst_addr0", lb_addr, 32'hFFFF_FFFC);
    tick();
    lb_rd_rdy = 1'b1; lb_rd_d = 32'h0102_0304;
    tick();
    lb_rd_rdy = 1'b0;
    collect_tx(1'b0, 1'b0, word);
    check("burst_word0", word, 32'h0102_0304);
    wait_rd("burst_rd1");
    check("burst_addr1", lb_addr, 32'h0000_0000);
    tick();
    lb_rd_rdy = 1'b1; lb_rd_d = 32'hA0B0_C0D0;
    tick();
    lb_rd_rdy = 1'b0;
    collect_tx(1'b0, 1'b1, word);
    check("burst_word1", word, 32'hA0B0_C0D0);
`else
    // Nonzero upper nibble is not a valid command in the default build
    err_base = err_cnt;
    tick();
    send_byte(8'h12);
    @(negedge clk_lb);
    check("no_burst_err", 32'(err_pulse), 32'd1);
    tick();
    @(negedge clk_lb);
    check("no_burst_idle", 32'(busy), 32'd0);
    check("no_burst_addr", lb_addr, 32'h0000_0030);
`endif

    // Reset mid-frame, then a clean write
    err_base = wr_cnt;
    tick();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b0;
    tick();
    @(negedge clk_lb);
    check("mid_rst_ctl", 32'(ctl), 32'd0);
    check("mid_rst_addr", lb_addr, 32'd0);
    check("mid_rst_wr_d", lb_wr_d, 32'd0);
    reset = 1'b1;
    send_hdr(8'h01, 32'h0000_0100);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    @(negedge clk_lb);
    check("post_rst_wr", 32'(lb_wr), 32'd1);
    check("post_rst_addr", lb_addr, 32'h0000_0100);
    check("post_rst_data", lb_wr_d, 32'hDEAD_BEEF);
    tick();
    @(negedge clk_lb);
    check("post_rst_wr_cnt", 32'(wr_cnt - err_base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
